// File: rtl/fetch_mem_responder_if.sv
// rtl/fetch_mem_responder_if.sv - fetcher/LSU request bus plus byte-wide RAM port
interface fetch_mem_responder_if #(
    parameter int RAM_ADDR_WIDTH = 17
);
    logic                      in_fetch_ena;
    logic [31:0]               in_fetch_addr;
    logic                      out_fetch_ready;
    logic [31:0]               out_fetch_inst;
    logic                      in_data_ena;
    logic                      in_data_wr;
    logic [1:0]                in_data_size;
    logic [31:0]               in_data_addr;
    logic [31:0]               in_data_wdata;
    logic                      out_data_ready;
    logic [31:0]               out_data_rdata;
    logic                      in_clear;
    logic [RAM_ADDR_WIDTH-1:0] out_ram_addr;
    logic                      out_ram_wr;
    logic [7:0]                out_ram_wdata;
    logic [7:0]                in_ram_data;

    modport slave (
        input  in_fetch_ena, in_fetch_addr, in_data_ena, in_data_wr, in_data_size,
               in_data_addr, in_data_wdata, in_clear, in_ram_data,
        output out_fetch_ready, out_fetch_inst, out_data_ready, out_data_rdata,
               out_ram_addr, out_ram_wr, out_ram_wdata
    );

    modport master (
        output in_fetch_ena, in_fetch_addr, in_data_ena, in_data_wr, in_data_size,
               in_data_addr, in_data_wdata, in_clear, in_ram_data,
        input  out_fetch_ready, out_fetch_inst, out_data_ready, out_data_rdata,
               out_ram_addr, out_ram_wr, out_ram_wdata
    );
endinterface

// File: rtl/fetch_mem_responder.sv
// rtl/fetch_mem_responder.sv - arbitrates fetch/data requests onto a byte-wide synchronous RAM
module fetch_mem_responder #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e                    state_q, state_d;
    logic                      fpend_q, fpend_d;
    logic [RAM_ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic                      dpend_q, dpend_d;
    logic                      dwr_q, dwr_d;
    logic [1:0]                dsize_q, dsize_d;
    logic [RAM_ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [31:0]               dwdata_q, dwdata_d;
    logic                      is_fetch_q, is_fetch_d;
    logic [RAM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                len_q, len_d;
    logic [31:0]               buf_q, buf_d;
    logic                      fready_q, fready_d;
    logic [31:0]               finst_q, finst_d;
    logic                      dready_q, dready_d;
    logic [31:0]               drdata_q, drdata_d;
    logic [1:0]                cap_idx;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{bus.in_fetch_addr[31:RAM_ADDR_WIDTH], bus.in_data_addr[31:RAM_ADDR_WIDTH]};

    // The byte arriving now belongs to the address driven one cycle earlier.
    assign cap_idx = cnt_q[1:0] - 2'd1;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'd0:    size_len = 3'd1;
            2'd1:    size_len = 3'd2;
            default: size_len = 3'd4;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fpend_q    <= 1'b0;
            faddr_q    <= '0;
            dpend_q    <= 1'b0;
            dwr_q      <= 1'b0;
            dsize_q    <= 2'd0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            is_fetch_q <= 1'b0;
            base_q     <= '0;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            buf_q      <= '0;
            fready_q   <= 1'b0;
            finst_q    <= '0;
            dready_q   <= 1'b0;
            drdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            fpend_q    <= fpend_d;
            faddr_q    <= faddr_d;
            dpend_q    <= dpend_d;
            dwr_q      <= dwr_d;
            dsize_q    <= dsize_d;
            daddr_q    <= daddr_d;
            dwdata_q   <= dwdata_d;
            is_fetch_q <= is_fetch_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            fready_q   <= fready_d;
            finst_q    <= finst_d;
            dready_q   <= dready_d;
            drdata_q   <= drdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fpend_d    = fpend_q;
        faddr_d    = faddr_q;
        dpend_d    = dpend_q;
        dwr_d      = dwr_q;
        dsize_d    = dsize_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        is_fetch_d = is_fetch_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        buf_d      = buf_q;
        fready_d   = 1'b0;
        finst_d    = finst_q;
        dready_d   = 1'b0;
        drdata_d   = drdata_q;

        // Same-cycle pulses join the pending view so an idle FSM starts without delay.
        if (bus.in_fetch_ena) begin
            fpend_d = 1'b1;
            faddr_d = bus.in_fetch_addr[RAM_ADDR_WIDTH-1:0];
        end
        if (bus.in_clear) begin
            fpend_d = 1'b0;
        end
        if (bus.in_data_ena) begin
            dpend_d  = 1'b1;
            dwr_d    = bus.in_data_wr;
            dsize_d  = bus.in_data_size;
            daddr_d  = bus.in_data_addr[RAM_ADDR_WIDTH-1:0];
            dwdata_d = bus.in_data_wdata;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                buf_d = '0;
                if (dpend_d) begin
                    dpend_d    = 1'b0;
                    is_fetch_d = 1'b0;
                    base_d     = daddr_d;
                    len_d      = size_len(dsize_d);
                    buf_d      = dwr_d ? dwdata_d : 32'd0;
                    state_d    = dwr_d ? WRITE : READ;
                end else if (fpend_d) begin
                    fpend_d    = 1'b0;
                    is_fetch_d = 1'b1;
                    base_d     = faddr_d;
                    len_d      = 3'd4;
                    state_d    = READ;
                end
            end
            READ: begin
                if (is_fetch_q && bus.in_clear) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        buf_d[{cap_idx, 3'b000} +: 8] = bus.in_ram_data;
                    end
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (is_fetch_q) begin
                            fready_d = 1'b1;
                            finst_d  = buf_d;
                        end else begin
                            dready_d = 1'b1;
                            drdata_d = buf_d;
                        end
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d  = IDLE;
                    cnt_d    = 3'd0;
                    dready_d = 1'b1;
                    drdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_fetch_ready = fready_q;
    assign bus.out_fetch_inst  = finst_q;
    assign bus.out_data_ready  = dready_q;
    assign bus.out_data_rdata  = drdata_q;
    assign bus.out_ram_wr      = (state_q == WRITE);
    assign bus.out_ram_wdata   = (state_q == WRITE) ? buf_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    assign bus.out_ram_addr    = (state_q == IDLE) ? '0 : base_q + RAM_ADDR_WIDTH'(cnt_q);
endmodule

// File: tb/tb_fetch_mem_responder.sv
// tb/tb_fetch_mem_responder.sv - directed vector bench for fetch_mem_responder
module tb_fetch_mem_responder;
    localparam int AW = 17;

    typedef struct {
        logic        is_fetch;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          n;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_mem_responder_if #(.RAM_ADDR_WIDTH(AW)) bus ();
    fetch_mem_responder #(.RAM_ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  mem [0:(1<<AW)-1] = '{default: 8'h00};
    logic        pre_we = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr[AW-1:0]] <= pre_data;
        else if (bus.out_ram_wr) mem[bus.out_ram_addr] <= bus.out_ram_wdata;
        bus.in_ram_data <= mem[bus.out_ram_addr];
    end

    int checks = 0;
    int errors = 0;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_fetch_ena = 1'b0; bus.in_fetch_addr = '0;
        bus.in_data_ena = 1'b0; bus.in_data_wr = 1'b0; bus.in_data_size = 2'd0;
        bus.in_data_addr = '0; bus.in_data_wdata = '0; bus.in_clear = 1'b0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rdy_cyc;
        int exp_cyc;
        logic rdy;
        logic [31:0] got;
        if (v.is_fetch) begin
            bus.in_fetch_ena = 1'b1; bus.in_fetch_addr = v.addr;
        end else begin
            bus.in_data_ena = 1'b1; bus.in_data_wr = v.wr; bus.in_data_size = v.size;
            bus.in_data_addr = v.addr; bus.in_data_wdata = v.wdata;
        end
        step();
        bus.in_fetch_ena = 1'b0; bus.in_data_ena = 1'b0;
        rdy_cyc = -1;
        exp_cyc = v.wr ? v.n + 1 : v.n + 2;
        got = '0;
        for (int c = 1; c <= 12 && rdy_cyc < 0; c++) begin
            if (c <= v.n) begin
                chk($sformatf("v%0d addr c%0d", idx, c), 32'(bus.out_ram_addr), (v.addr + 32'(c - 1)) & 32'h1FFFF);
                chk($sformatf("v%0d wr c%0d", idx, c), 32'(bus.out_ram_wr), 32'(v.wr));
                if (v.wr) chk($sformatf("v%0d wdata c%0d", idx, c), 32'(bus.out_ram_wdata), (v.wdata >> (8 * (c - 1))) & 32'hFF);
            end
            rdy = v.is_fetch ? bus.out_fetch_ready : bus.out_data_ready;
            if (rdy) begin
                rdy_cyc = c;
                got = v.is_fetch ? bus.out_fetch_inst : bus.out_data_rdata;
            end else begin
                step();
            end
        end
        chk($sformatf("v%0d ready cycle", idx), 32'(rdy_cyc), 32'(exp_cyc));
        chk($sformatf("v%0d data", idx), got, v.exp_rdata);
        step();
        chk($sformatf("v%0d ready pulse", idx), 32'(v.is_fetch ? bus.out_fetch_ready : bus.out_data_ready), 32'd0);
        chk($sformatf("v%0d data held", idx), v.is_fetch ? bus.out_fetch_inst : bus.out_data_rdata, v.exp_rdata);
    endtask

    int fr_cyc, dr_cyc, seen;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h0000_0513, 4};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 4};
        vecs[2] = '{1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 4};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 32'h0000_0022, 32'h0, 32'h0000_00AD, 1};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 32'h0001_FFFF, 32'h0, 32'h0000_1234, 2};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 32'h0000_0030, 32'h1111_CAFE, 32'h0, 2};
        vecs[6] = '{1'b0, 1'b0, 2'd3, 32'h0000_0030, 32'h0, 32'h0000_CAFE, 4};
        vecs[7] = '{1'b0, 1'b1, 2'd0, 32'h0000_0050, 32'h0000_99AB, 32'h0, 1};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 32'h0000_0050, 32'h0, 32'h0000_00AB, 1};
        vecs[9] = '{1'b0, 1'b0, 2'd2, 32'hFFF0_0100, 32'h0, 32'h0000_0513, 4};

        idle_inputs();
        rst = 1'b0;
        step();
        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h1FFFF, 8'h34);
        preload(32'h0, 8'h12);
        preload(32'h40, 8'h80);
        rst = 1'b1;
        step();

        chk("reset ram_addr", 32'(bus.out_ram_addr), 32'h0);
        chk("reset ram_wr", 32'(bus.out_ram_wr), 32'h0);
        chk("reset ram_wdata", 32'(bus.out_ram_wdata), 32'h0);
        chk("reset readys", {30'd0, bus.out_fetch_ready, bus.out_data_ready}, 32'h0);
        chk("reset inst", bus.out_fetch_inst, 32'h0);
        chk("reset rdata", bus.out_data_rdata, 32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Collision: data first, fetch starts at the end of the load's ready cycle.
        bus.in_fetch_ena = 1'b1; bus.in_fetch_addr = 32'h0;
        bus.in_data_ena = 1'b1; bus.in_data_wr = 1'b0; bus.in_data_size = 2'd0; bus.in_data_addr = 32'h40;
        step();
        bus.in_fetch_ena = 1'b0; bus.in_data_ena = 1'b0;
        fr_cyc = -1; dr_cyc = -1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) chk("coll load addr", 32'(bus.out_ram_addr), 32'h40);
            if (c == 5) chk("coll fetch addr1", 32'(bus.out_ram_addr), 32'h1);
            if (bus.out_data_ready && dr_cyc < 0) begin
                dr_cyc = c;
                chk("coll load data", bus.out_data_rdata, 32'h80);
            end
            if (bus.out_fetch_ready && fr_cyc < 0) begin
                fr_cyc = c;
                chk("coll fetch data", bus.out_fetch_inst, 32'h12);
            end
            step();
        end
        chk("coll load ready cycle", 32'(dr_cyc), 32'd3);
        chk("coll fetch ready cycle", 32'(fr_cyc), 32'd9);

        // Flush in cycle 3 of a fetch.
        bus.in_fetch_ena = 1'b1; bus.in_fetch_addr = 32'h100;
        step();
        bus.in_fetch_ena = 1'b0;
        step(); step();
        bus.in_clear = 1'b1;
        step();
        bus.in_clear = 1'b0;
        chk("flush idle addr", 32'(bus.out_ram_addr), 32'h0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_fetch_ready) seen = 1;
            step();
        end
        chk("flush no fetch ready", 32'(seen), 32'd0);

        // Store under continuous flush, with a flushed fetch pulse mid-store.
        bus.in_clear = 1'b1;
        bus.in_data_ena = 1'b1; bus.in_data_wr = 1'b1; bus.in_data_size = 2'd2;
        bus.in_data_addr = 32'h60; bus.in_data_wdata = 32'h1122_3344;
        step();
        bus.in_data_ena = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("flush store wr c%0d", c), 32'(bus.out_ram_wr), 32'd1);
            chk($sformatf("flush store addr c%0d", c), 32'(bus.out_ram_addr), 32'h60 + 32'(c - 1));
            bus.in_fetch_ena = (c == 2); bus.in_fetch_addr = 32'h100;
            step();
        end
        bus.in_fetch_ena = 1'b0;
        chk("flush store ready", 32'(bus.out_data_ready), 32'd1);
        bus.in_clear = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_fetch_ready || bus.out_ram_addr != '0) seen = 1;
            step();
        end
        chk("flushed fetch dropped", 32'(seen), 32'd0);
        chk("flush store ram", {mem[32'h63], mem[32'h62], mem[32'h61], mem[32'h60]}, 32'h1122_3344);

        // Load pulsed while a fetch is busy waits for it.
        bus.in_fetch_ena = 1'b1; bus.in_fetch_addr = 32'h100;
        step();
        bus.in_fetch_ena = 1'b0;
        fr_cyc = -1; dr_cyc = -1;
        for (int c = 1; c <= 14; c++) begin
            bus.in_data_ena = (c == 2); bus.in_data_wr = 1'b0; bus.in_data_size = 2'd0; bus.in_data_addr = 32'h40;
            if (c == 7) chk("busy load addr", 32'(bus.out_ram_addr), 32'h40);
            if (bus.out_fetch_ready && fr_cyc < 0) fr_cyc = c;
            if (bus.out_data_ready && dr_cyc < 0) begin
                dr_cyc = c;
                chk("busy load data", bus.out_data_rdata, 32'h80);
            end
            step();
        end
        bus.in_data_ena = 1'b0;
        chk("busy fetch ready cycle", 32'(fr_cyc), 32'd6);
        chk("busy load ready cycle", 32'(dr_cyc), 32'd9);

        // Second fetch pulse while pending overwrites the first.
        bus.in_data_ena = 1'b1; bus.in_data_wr = 1'b1; bus.in_data_size = 2'd2;
        bus.in_data_addr = 32'h70; bus.in_data_wdata = 32'h0;
        step();
        bus.in_data_ena = 1'b0;
        fr_cyc = -1;
        for (int c = 1; c <= 16; c++) begin
            bus.in_fetch_ena = (c == 1 || c == 2);
            bus.in_fetch_addr = (c == 1) ? 32'h0 : 32'h100;
            if (c == 6) chk("overwrite fetch addr", 32'(bus.out_ram_addr), 32'h100);
            if (bus.out_fetch_ready && fr_cyc < 0) begin
                fr_cyc = c;
                chk("overwrite fetch data", bus.out_fetch_inst, 32'h513);
            end
            step();
        end
        bus.in_fetch_ena = 1'b0;
        chk("overwrite ready cycle", 32'(fr_cyc), 32'd11);

        // Reset in cycle 2 of a store, with a fetch pending.
        bus.in_data_ena = 1'b1; bus.in_data_wr = 1'b1; bus.in_data_size = 2'd2;
        bus.in_data_addr = 32'h80; bus.in_data_wdata = 32'hCAFE_F00D;
        step();
        bus.in_data_ena = 1'b0;
        bus.in_fetch_ena = 1'b1; bus.in_fetch_addr = 32'h100;
        step();
        bus.in_fetch_ena = 1'b0;
        rst = 1'b0;
        step();
        chk("rst ram_wr", 32'(bus.out_ram_wr), 32'h0);
        chk("rst ram_addr", 32'(bus.out_ram_addr), 32'h0);
        chk("rst ram_wdata", 32'(bus.out_ram_wdata), 32'h0);
        chk("rst readys", {30'd0, bus.out_fetch_ready, bus.out_data_ready}, 32'h0);
        chk("rst inst", bus.out_fetch_inst, 32'h0);
        chk("rst rdata", bus.out_data_rdata, 32'h0);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_fetch_ready || bus.out_data_ready) seen = 1;
            step();
        end
        chk("rst pending lost", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_mem_responder.md
# fetch_mem_responder

Memory-side responder for the instruction fetcher's refill requests and the load/store unit's data requests. It latches one-cycle request pulses and arbitrates between them, data first. It then serialises each access onto the byte-wide synchronous RAM port and returns the assembled little-endian word with a one-cycle ready pulse. It sits between the fetcher/LSB and the external RAM.

## Interface
- RAM_ADDR_WIDTH, 17, number of RAM address bits driven; upper address bits are ignored.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_fetch_ena  input  1  one-cycle fetch request pulse.
- in_fetch_addr  input  32  fetch byte address, sampled with in_fetch_ena.
- out_fetch_ready  output  1  one-cycle pulse; out_fetch_inst valid this cycle.
- out_fetch_inst  output  32  fetched instruction word.
- in_data_ena  input  1  one-cycle data request pulse.
- in_data_wr  input  1  1 = store, 0 = load.
- in_data_size  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- in_data_addr  input  32  data byte address.
- in_data_wdata  input  32  store data; the low N bytes are used.
- out_data_ready  output  1  one-cycle pulse on load data return or store completion.
- out_data_rdata  output  32  load data, zero-extended; 0 for stores.
- in_clear  input  1  mispredict flush; aborts fetch activity only.
- out_ram_addr  output  RAM_ADDR_WIDTH  RAM byte address.
- out_ram_wr  output  1  RAM write strobe.
- out_ram_wdata  output  8  RAM write byte.
- in_ram_data  input  8  RAM read byte; valid the cycle after its address is driven.

## Operation
- **Reset** (rst low at an edge):
  - All outputs go to 0; state = IDLE.
  - Fetch and data pending latches are cleared; byte counter = 0.
- **Request latching**:
  - in_fetch_ena sets fetch-pending and captures the address; in_data_ena does the same for data (address, wr, size, wdata).
  - A request pulse is latched even while busy.
  - A second request of the same kind while one is pending overwrites the first.
- **Arbitration in IDLE**: data-pending beats fetch-pending. Starting a transaction clears its pending bit.
- **States**:
  - IDLE: no transaction in progress.
  - READ: driving addresses A+k for k = 0..N-1 and capturing bytes; one extra capture cycle follows the last address.
  - WRITE: driving address A+k, out_ram_wr = 1 and wdata byte k for k = 0..N-1.
- **Access size**: N = 4 for fetch; N = 1, 2 or 4 for data.
- **Read assembly**: byte k goes to result bits [8k+7:8k]; unfilled bytes are 0.
- **Address arithmetic**: A+k is modulo 2^RAM_ADDR_WIDTH, so addresses wrap at the top of RAM.
- **Flush (in_clear high)**:
  - Discards fetch-pending, including a same-cycle in_fetch_ena.
  - Aborts an in-progress fetch READ and returns to IDLE at that edge; no out_fetch_ready is produced.
  - Data transactions and data-pending are unaffected; a store is never interrupted.
- **Bus rules**:
  - out_ram_wr = 0 whenever not in WRITE.
  - out_ram_addr = 0 and out_ram_wdata = 0 in IDLE.
- **Outputs on completion**:
  - out_fetch_inst and out_data_rdata hold their last value after the ready pulse.
  - Ready outputs are never high for more than one cycle.

## Timing
- Cycle 0 = the cycle in which the request is sampled with the FSM idle and the request has priority.
- **Read of N bytes**:
  - Address A+k is driven in cycle k+1.
  - Byte k is captured at the end of cycle k+2.
  - Ready pulses in cycle N+2 with data; fetch word ready = cycle 6.
- **Write of N bytes**:
  - Byte k is written in cycle k+1.
  - out_data_ready pulses in cycle N+1; word store ready = cycle 5.
- The ready cycle is spent in IDLE; a pending request may start at the end of that cycle, so the next address appears in the following cycle.
- A request waiting behind an active transaction is delayed by the remaining length of that transaction; nothing is lost.
- Reset mid-transaction: at the reset edge, ready is not asserted, the RAM strobe drops, and all pending requests are lost.

## Test plan
- **Fetch**: RAM[0x100..0x103] = 13 05 00 00; fetch pulse at 0x100.
  - out_ram_addr = 0x100..0x103 in cycles 1-4.
  - out_fetch_ready in cycle 6 with out_fetch_inst = 0x00000513.
- **Store word**: 0xDEADBEEF to 0x20.
  - Writes EF, BE, AD, DE to 0x20..0x23 in cycles 1-4 with out_ram_wr = 1.
  - out_data_ready in cycle 5.
- **Collision**: fetch 0x0 and byte load 0x40 (RAM = 0x80) pulsed the same cycle.
  - Load served first; out_data_rdata = 0x00000080 in cycle 3.
  - The fetch starts next, and its ready follows 6 cycles after its start.
- **Flush**: in_clear in cycle 3 of a fetch.
  - No out_fetch_ready is ever produced and the FSM is in IDLE in cycle 4.
  - A flush during a store still writes all 4 bytes.
- **Half load and wrap**:
  - Half load at 0x1FFFF reads 0x1FFFF then 0x00000.
  - Reset low in cycle 2 of a store: out_ram_wr = 0 and all outputs are 0 the next cycle.
